// File: rtl/color_pkg.sv
// Shared FSM/phase types and TCS-style sensor filter codes for the colour scan sequencer.
package color_pkg;

  localparam int CNT_W_DEF = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_STORE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_RED   = 2'd0,
    PH_BLUE  = 2'd1,
    PH_GREEN = 2'd2,
    PH_CLEAR = 2'd3
  } phase_e;

  // {s2, s3}
  localparam logic [1:0] S23_RED   = 2'b00;
  localparam logic [1:0] S23_BLUE  = 2'b01;
  localparam logic [1:0] S23_GREEN = 2'b11;
  localparam logic [1:0] S23_CLEAR = 2'b10;

  function automatic logic [1:0] phase_code(input phase_e ph);
    case (ph)
      PH_RED:   return S23_RED;
      PH_BLUE:  return S23_BLUE;
      PH_GREEN: return S23_GREEN;
      default:  return S23_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/color_pulse_counter.sv
// Synchronises the asynchronous sensor output, detects rising edges and counts them
// while enabled; the count saturates at all-ones and raises a sticky flag.
module color_pulse_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_out,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             w_rise;

  assign w_rise = r_sync2 & ~r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sync1 <= i_out;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_clr) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (i_en && w_rise && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_MAX_M1) r_sat <= 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/color_scan_sequencer.sv
// Steps the colour sensor through RED/BLUE/GREEN filters, counting pulses per phase and
// publishing all channels at once with a valid/ready handshake. CLEAR_CHANNEL_EN adds a CLEAR phase.
module color_scan_sequencer
  import color_pkg::*;
#(
  parameter int SETTLE_CYC = 50000,
  parameter int GATE_CYC   = 500000,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             i_clk_color_50,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_out,
  output logic             o_s0,
  output logic             o_s1,
  output logic             o_s2,
  output logic             o_s3,
  output logic [CNT_W-1:0] o_red_cnt,
  output logic [CNT_W-1:0] o_green_cnt,
  output logic [CNT_W-1:0] o_blue_cnt,
`ifdef CLEAR_CHANNEL_EN
  output logic [CNT_W-1:0] o_clear_cnt,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_sat
);

  localparam int TMR_MAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_END   = TMR_W'(GATE_CYC - 1);
`ifdef CLEAR_CHANNEL_EN
  localparam phase_e PH_LAST = PH_CLEAR;
`else
  localparam phase_e PH_LAST = PH_GREEN;
`endif

  state_e           r_state;
  phase_e           r_phase;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_sh_red, r_sh_green, r_sh_blue;
  logic [CNT_W-1:0] r_red, r_green, r_blue;
  logic             r_sat_acc, r_sat, r_valid, r_busy;
  logic [1:0]       r_s23;
  logic [CNT_W-1:0] w_cnt;
  logic             w_sat;
`ifdef CLEAR_CHANNEL_EN
  logic [CNT_W-1:0] r_sh_clear, r_clear;
`endif

  color_pulse_counter #(.CNT_W(CNT_W)) u_pulse (
    .i_clk (i_clk_color_50),
    .i_rst (i_rst),
    .i_out (i_out),
    .i_en  (r_state == ST_GATE),
    .i_clr (r_state == ST_SETTLE),
    .o_cnt (w_cnt),
    .o_sat (w_sat)
  );

  always_ff @(posedge i_clk_color_50 or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_RED;
      r_tmr      <= '0;
      r_sh_red   <= '0;
      r_sh_green <= '0;
      r_sh_blue  <= '0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
      r_sat_acc  <= 1'b0;
      r_sat      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_s23      <= 2'b00;
`ifdef CLEAR_CHANNEL_EN
      r_sh_clear <= '0;
      r_clear    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_SETTLE;
            r_phase   <= PH_RED;
            r_tmr     <= '0;
            r_sat_acc <= 1'b0;
            r_busy    <= 1'b1;
            r_s23     <= S23_RED;
          end
        end
        ST_SETTLE, ST_GATE, ST_STORE: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_s23   <= 2'b00;
          end else if (r_state == ST_SETTLE) begin
            r_tmr <= (r_tmr == SETTLE_END) ? '0 : r_tmr + 1'b1;
            if (r_tmr == SETTLE_END) r_state <= ST_GATE;
          end else if (r_state == ST_GATE) begin
            r_tmr <= (r_tmr == GATE_END) ? '0 : r_tmr + 1'b1;
            if (r_tmr == GATE_END) r_state <= ST_STORE;
          end else begin
            case (r_phase)
              PH_RED:   r_sh_red   <= w_cnt;
              PH_BLUE:  r_sh_blue  <= w_cnt;
              PH_GREEN: r_sh_green <= w_cnt;
`ifdef CLEAR_CHANNEL_EN
              PH_CLEAR: r_sh_clear <= w_cnt;
`endif
              default: ;
            endcase
            r_sat_acc <= r_sat_acc | w_sat;
            if (r_phase == PH_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_s23   <= 2'b00;
            end else begin
              r_state <= ST_SETTLE;
              r_phase <= phase_e'(r_phase + 2'd1);
              r_tmr   <= '0;
              r_s23   <= phase_code(phase_e'(r_phase + 2'd1));
            end
          end
        end
        ST_DONE: begin
          // First DONE cycle publishes the whole scan; afterwards wait for ready.
          if (!r_valid) begin
            r_red   <= r_sh_red;
            r_green <= r_sh_green;
            r_blue  <= r_sh_blue;
`ifdef CLEAR_CHANNEL_EN
            r_clear <= r_sh_clear;
`endif
            r_sat   <= r_sat_acc;
            r_valid <= 1'b1;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            if (i_start) begin
              r_state   <= ST_SETTLE;
              r_phase   <= PH_RED;
              r_tmr     <= '0;
              r_sat_acc <= 1'b0;
              r_busy    <= 1'b1;
              r_s23     <= S23_RED;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s0        = r_busy;
  assign o_s1        = r_busy;
  assign o_s2        = r_s23[1];
  assign o_s3        = r_s23[0];
  assign o_busy      = r_busy;
  assign o_valid     = r_valid;
  assign o_sat       = r_sat;
  assign o_red_cnt   = r_red;
  assign o_green_cnt = r_green;
  assign o_blue_cnt  = r_blue;
`ifdef CLEAR_CHANNEL_EN
  assign o_clear_cnt = r_clear;
`endif

endmodule

// File: tb/tb_color_scan_sequencer.sv
// Directed bench for color_scan_sequencer (CNT_W=8 and CNT_W=5 instances side by side);
// honours CLEAR_CHANNEL_EN for the fourth phase.
module tb_color_scan_sequencer;

  localparam int SC = 4;
  localparam int GC = 100;
`ifdef CLEAR_CHANNEL_EN
  localparam int NPH = 4;
`else
  localparam int NPH = 3;
`endif
  localparam int PH_LEN = SC + GC + 1;
  localparam int LAT    = NPH * PH_LEN + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, sout = 1'b0, ready = 1'b0;
  logic s0, s1, s2, s3, valid, busy, sat;
  logic [7:0] rc, gc, bc;
  logic s0_5, s1_5, s2_5, s3_5, valid5, busy5, sat5;
  logic [4:0] rc5, gc5, bc5;
`ifdef CLEAR_CHANNEL_EN
  logic [7:0] cc;
  logic [4:0] cc5;
`endif

  typedef struct {
    int r; int g; int b; int s;
    int r5; int g5; int b5; int s5;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;
  int half = 5;

  color_scan_sequencer #(.SETTLE_CYC(SC), .GATE_CYC(GC), .CNT_W(8)) dut (
    .i_clk_color_50(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_out(sout),
    .o_s0(s0), .o_s1(s1), .o_s2(s2), .o_s3(s3),
    .o_red_cnt(rc), .o_green_cnt(gc), .o_blue_cnt(bc),
`ifdef CLEAR_CHANNEL_EN
    .o_clear_cnt(cc),
`endif
    .o_valid(valid), .i_ready(ready), .o_busy(busy), .o_sat(sat)
  );

  color_scan_sequencer #(.SETTLE_CYC(SC), .GATE_CYC(GC), .CNT_W(5)) dut5 (
    .i_clk_color_50(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_out(sout),
    .o_s0(s0_5), .o_s1(s1_5), .o_s2(s2_5), .o_s3(s3_5),
    .o_red_cnt(rc5), .o_green_cnt(gc5), .o_blue_cnt(bc5),
`ifdef CLEAR_CHANNEL_EN
    .o_clear_cnt(cc5),
`endif
    .o_valid(valid5), .i_ready(ready), .o_busy(busy5), .o_sat(sat5)
  );

  always #5 clk = ~clk;

  // Free-running sensor square wave; any GC-cycle window sees exactly GC/(2*half) rises.
  initial begin
    forever begin
      repeat (half) @(posedge clk);
      #2 sout = ~sout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] code_at(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic start_scan();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int busy_n, output int seq_err, output int pwr_err);
    lat = 0; busy_n = 0; seq_err = 0; pwr_err = 0;
    while (!valid && lat < 2000) begin
      if (busy) begin
        if ({s2, s3} !== code_at(busy_n / PH_LEN)) seq_err++;
        busy_n++;
      end
      if ({s2_5, s3_5} !== {s2, s3}) seq_err++;
      if (s0 !== busy || s1 !== busy || s0_5 !== busy || s1_5 !== busy || busy5 !== busy) pwr_err++;
      step();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, output exp_t e);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    e = '{default: -1};
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid5"}, valid5, 1);
      check({tag, "_red"},   rc,  e.r);
      check({tag, "_green"}, gc,  e.g);
      check({tag, "_blue"},  bc,  e.b);
      check({tag, "_sat"},   sat, e.s);
      check({tag, "_red5"},   rc5,  e.r5);
      check({tag, "_green5"}, gc5,  e.g5);
      check({tag, "_blue5"},  bc5,  e.b5);
      check({tag, "_sat5"},   sat5, e.s5);
`ifdef CLEAR_CHANNEL_EN
      check({tag, "_clear"},  cc,  e.r);
      check({tag, "_clear5"}, cc5, e.r5);
`endif
    end
  endtask

  initial begin
    int lat, bn, se, pe, viol;
    exp_t e;

    // Reset state, sampled while rst is held
    repeat (3) step();
    check("rst_s0123", {s0, s1, s2, s3}, 0);
    check("rst_counts", {rc, gc, bc}, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // Scan 1: period-10 input -> 10 counts everywhere
    sb.push_back('{10, 10, 10, 0, 10, 10, 10, 0});
    start_scan();
    wait_valid(lat, bn, se, pe);
    check("scan1_latency", lat, LAT);
    check("scan1_busy_cycles", bn, NPH * PH_LEN);
    check("scan1_filter_seq_err", se, 0);
    check("scan1_power_err", pe, 0);
    check("scan1_done_busy", busy, 0);
    check_result("scan1", e);

    // Hold with ready=0: outputs frozen
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valid !== 1'b1 || rc !== 8'(e.r) || gc !== 8'(e.g) || bc !== 8'(e.b) || sat !== e.s[0]) viol++;
    end
    check("hold_violations", viol, 0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("ready_valid_drop", valid, 0);
    check("ready_to_idle_busy", busy, 0);
    check("hold_counts_after_drop", rc, 10);

    // Scan 2: period-2 input -> 50 counts; 5-bit instance saturates at 31
    half = 1;
    repeat (4) step();
    sb.push_back('{50, 50, 50, 0, 31, 31, 31, 1});
    start_scan();
    wait_valid(lat, bn, se, pe);
    check("scan2_latency", lat, LAT);
    check_result("scan2", e);

    // start + ready together in DONE: straight into SETTLE/RED
    sb.push_back('{50, 50, 50, 0, 31, 31, 31, 1});
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b0;
    check("restart_valid", valid, 0);
    check("restart_busy", busy, 1);
    check("restart_s23", {s2, s3}, 0);
    wait_valid(lat, bn, se, pe);
    check("scan3_latency", lat, LAT);
    check("scan3_filter_seq_err", se, 0);
    check_result("scan3", e);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("scan3_ready_drop", valid, 0);

    // Abort in BLUE GATE: back to IDLE, previous results retained, no valid
    half = 5;
    repeat (4) step();
    start_scan();
    repeat (149) step();
    check("abort_pre_s23", {s2, s3}, 2'b01);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_s0", s0, 0);
    check("abort_red_kept", rc, 50);
    check("abort_blue_kept", bc, 50);
    check("abort_red5_kept", rc5, 31);
    check("abort_sat5_kept", sat5, 1);
    repeat (20) step();
    check("abort_valid_later", valid, 0);

    // Reset during RED GATE: immediate clear, no partial result
    start_scan();
    repeat (20) step();
    rst = 1'b1;
    #1;
    check("midrst_counts", {rc, gc, bc}, 0);
    check("midrst_pins", {s0, s1, s2, s3}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_sat5", sat5, 0);
    step();
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("midrst_no_partial", viol, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/color_scan_sequencer.md
COLOR_SCAN_SEQUENCER -- requirements
Module: color_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 50000, meaning clocks to wait after each filter change before counting.
REQ-002 Parameter GATE_CYC, default 500000, meaning clock-count window per filter phase.
REQ-003 Parameter CNT_W, default 22, meaning width of each per-channel pulse count.
REQ-004 clk_color_50  input  1  sole clock, 50 MHz; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request one full RGB scan; sampled in IDLE, or in DONE when ready=1.
REQ-007 abort  input  1  cancel the scan in progress.
REQ-008 out  input  1  sensor frequency output, asynchronous to clk_color_50.
REQ-009 s0, s1  output  1 each  sensor frequency-scale/power pins.
REQ-010 s2, s3  output  1 each  sensor photodiode filter select.
REQ-011 red_cnt, green_cnt, blue_cnt  output  CNT_W each  latched counts from the last completed scan.
REQ-012 valid / ready  output / input  1 each  result handshake.
REQ-013 busy  output  1  high in every state except IDLE and DONE.
REQ-014 sat  output  1  high if any channel count saturated in the last completed scan.

Function
REQ-015 FSM states: IDLE, SETTLE, GATE, STORE, DONE; shared across phases by a phase index.
REQ-016 Phase order and filter codes: RED (s2=0,s3=0), BLUE (0,1), GREEN (1,1).
REQ-017 IDLE with start=1 goes to SETTLE, phase=RED, settle counter cleared, next cycle.
REQ-018 SETTLE holds s2/s3 at the phase code for exactly SETTLE_CYC cycles, then goes to GATE with the pulse counter cleared.
REQ-019 out passes through a 2-flop synchronizer plus edge detector; each synchronized rising edge inside GATE increments the pulse counter by 1.
REQ-020 Pulse counter saturates at 2^CNT_W-1, does not wrap, and sets the scan's sticky saturation bit.
REQ-021 GATE lasts exactly GATE_CYC cycles, then goes to STORE.
REQ-022 STORE, one cycle: writes the pulse counter to the shadow register for the phase; advances to SETTLE for the next phase, or to DONE after GREEN.
REQ-023 On entry to DONE, the three shadow registers and sat load into the outputs in one cycle, and valid=1.
REQ-024 Outputs hold stable while valid=1.
REQ-025 DONE with ready=1: valid drops next cycle; goes to SETTLE/RED if start=1 in that same cycle, else IDLE.
REQ-026 start is ignored in SETTLE, GATE and STORE.
REQ-027 abort=1 in SETTLE, GATE or STORE goes to IDLE next cycle: outputs and valid unchanged, shadow registers discarded.
REQ-028 abort has priority over state advance in the same cycle; abort in IDLE or DONE has no effect.
REQ-029 s0=s1=1 (100% scale) whenever busy=1; s0=s1=0 (power-down) in IDLE and DONE.
REQ-030 Scan latency from start accepted to valid=1: 3*(SETTLE_CYC+GATE_CYC+1)+1 cycles.

Reset
REQ-031 rst=1 forces state IDLE and clears all counters, shadows, synchronizer flops and sticky bits.
REQ-032 During rst: s0=s1=s2=s3=0, red_cnt=green_cnt=blue_cnt=0, valid=0, busy=0, sat=0.
REQ-033 rst mid-scan takes effect immediately; no partial result is reported.

Configuration
REQ-034 With CLEAR_CHANNEL_EN defined, a fourth phase CLEAR (s2=1,s3=0) follows GREEN.
REQ-035 With CLEAR_CHANNEL_EN defined, the module adds output clear_cnt (CNT_W wide) and the REQ-030 latency uses factor 4.
REQ-036 Without CLEAR_CHANNEL_EN, neither the CLEAR phase nor the clear_cnt port exists.

Structure
REQ-037 Package color_pkg holds the FSM state enum, the phase enum, the filter-code constants (S23_RED, S23_BLUE, S23_GREEN, S23_CLEAR) and the default CNT_W.
REQ-038 Sub-module color_pulse_counter contains synchronizer, edge detect, enable, clear and saturating count; the FSM lives in the top module.

Verification (SETTLE_CYC=4, GATE_CYC=100, CNT_W=8)
REQ-039 out period 10 clocks, first edge 3 cycles after GATE entry, one start -> valid after 316 cycles; each count=10, sat=0.
REQ-040 s2/s3 monitor during a scan -> sequence 00, 01, 11, each held 105 cycles; s0=s1=1 only while busy.
REQ-041 ready=0 for 50 cycles after valid -> counts and valid stable for all 50 cycles; ready=1 -> valid=0 next cycle, IDLE.
REQ-042 out toggling every cycle (period 2) -> each count=50; with CNT_W=5 -> counts=31, sat=1.
REQ-043 abort in the BLUE GATE phase -> IDLE next cycle, valid stays 0, prior outputs unchanged; rst mid-GATE -> all outputs 0.
REQ-044 start and ready both high in DONE -> valid=0 and state SETTLE/RED in the next cycle; with CLEAR_CHANNEL_EN -> latency 421 cycles and fourth code 10.
